// File: rtl/instr_mem_resp_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Word-index math lives here so the FSM and array agree on it.
`ifndef XLEN
`define XLEN 32
`endif

package instr_mem_resp_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [`XLEN-1:0] word_idx(
        input logic [`XLEN-1:0] addr
    );
        return addr >> 2;
    endfunction

    function automatic logic word_oob(
        input logic [`XLEN-1:0] addr,
        input logic [`XLEN-1:0] depth
    );
        return word_idx(addr) >= depth;
    endfunction

endpackage

// File: rtl/instr_mem_resp_imem_array.sv
// Program storage: one synchronous read port, one write port.
// A same-edge read of a word being written returns the old word.
module imem_array #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_idx,
    output logic [XLEN-1:0] rd_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder behind the fetch stage: wait states,
// stall back-pressure, branch flush and a program-load write port.
`ifndef XLEN
`define XLEN 32
`endif

module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int              XLEN        = `XLEN,
    parameter int              DEPTH       = 1024,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0] NOP_INSTR   =
        XLEN'(instr_mem_resp_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_addr,
    output logic            instr_valid,
    output logic            instr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic HAS_WAIT = (WAIT_CYCLES != 0);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic [XLEN-1:0] addr_q;

    logic            accept;
    logic            last_wait;
    logic            resp_fire;
    logic [XLEN-1:0] resp_addr;
    logic            resp_err;
    logic [XLEN-1:0] resp_word;
    logic [XLEN-1:0] wr_word;
    logic            rd_en;
    logic            wr_ok;
    logic [XLEN-1:0] rd_data;

    logic [XLEN-1:0] out_addr_q;
    logic            out_err_q;
    logic            out_nop_q;
    logic            unused_bits;

    // A flush lets a new request in even while a wait is running.
    assign accept    = req_valid && ((state != BUSY) || flush);
    assign last_wait = (state == BUSY) && (cnt == 4'd1);
    assign resp_fire = (accept && !HAS_WAIT) || (last_wait && !flush);
    assign resp_addr = accept ? req_addr : addr_q;

    assign resp_err  = (resp_addr[1:0] != 2'b00)
                    || word_oob(resp_addr, XLEN'(DEPTH));
    assign resp_word = word_idx(resp_addr);
    assign wr_word   = word_idx(wr_addr);
    assign rd_en     = resp_fire && !resp_err;
    assign wr_ok     = wr_en && !word_oob(wr_addr, XLEN'(DEPTH));

    // Released one cycle early so fetch advances on the response edge.
    assign stall = rst
                && (((state == BUSY) && (cnt != 4'd1))
                 || (accept && HAS_WAIT));

    assign unused_bits = ^{resp_word[XLEN-1:AW],
                           wr_word[XLEN-1:AW],
                           wr_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nxt = HAS_WAIT ? BUSY : RESP;
                    cnt_nxt   = WAIT_LD;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    state_nxt = HAS_WAIT ? BUSY : RESP;
                    cnt_nxt   = WAIT_LD;
                end else if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_addr_q <= '0;
            out_err_q  <= 1'b0;
            out_nop_q  <= 1'b1;
        end else if (resp_fire) begin
            out_addr_q <= resp_addr;
            out_err_q  <= resp_err;
            out_nop_q  <= resp_err;
        end
    end

    imem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (resp_word[AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_ok),
        .wr_idx  (wr_word[AW-1:0]),
        .wr_data (wr_data)
    );

    assign instr_valid = (state == RESP);
    assign instr_err   = instr_valid && out_err_q;
    assign instr       = out_nop_q ? NOP_INSTR : rd_data;
    assign instr_addr  = out_addr_q;

endmodule
